// File: rtl/soc_pkg.sv
// Shared SOC constants and types: timebase prescale, bus field types, timebase CSR map.
// Latency: n/a (types, constants and one pure helper function only).
// Backpressure: n/a.
package soc_pkg;

  // Prescaler terminal count for an 80 MHz core clock (80 clocks per microsecond)
  localparam int NUM_1US_CLKS = 79;

  typedef logic [6:0]  cnt_1us_t;
  typedef logic [31:0] soc_addr_t;
  typedef logic [3:0]  soc_we_t;
  typedef logic [31:0] soc_data_t;

  // Timebase register word offsets, decoded from bus_addr[4:2]
  localparam logic [2:0] TB_CTRL   = 3'd0;
  localparam logic [2:0] TB_LOAD   = 3'd1;
  localparam logic [2:0] TB_COUNT  = 3'd2;
  localparam logic [2:0] TB_STATUS = 3'd3;
  localparam logic [2:0] TB_USEC   = 3'd4;

  // CTRL register layout: bit1 ONESHOT, bit0 EN
  typedef struct packed {
    logic oneshot;
    logic en;
  } tb_ctrl_t;

  // Merge new write data into an existing word, one byte lane per enable bit
  function automatic soc_data_t apply_byte_we(soc_data_t old_dat, soc_data_t new_dat, soc_we_t we);
    soc_data_t res;
    res = old_dat;
    for (int b = 0; b < 4; b++) begin
      if (we[b]) res[8*b +: 8] = new_dat[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/soc_timebase_div.sv
// Clock divider producing a 1 us strobe and a 1 ms strobe from the core clock.
// Latency: strobes are decoded combinationally from the divider counters (no extra register stage).
// Backpressure: none; free-running, strobes cannot be stalled.
module soc_timebase_div #(
  parameter int NUM_1US_CLKS = soc_pkg::NUM_1US_CLKS,
  parameter int MS_DIV       = 1000
) (
  input  logic clk,
  input  logic arst,
  output logic tick_1us,
  output logic tick_1ms
);
  import soc_pkg::*;

  localparam int MS_W = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;
  localparam cnt_1us_t        PRE_LAST = cnt_1us_t'(NUM_1US_CLKS);
  localparam logic [MS_W-1:0] MS_LAST  = MS_W'(MS_DIV - 1);

  cnt_1us_t        pre_cnt;
  logic [MS_W-1:0] ms_cnt;

  assign tick_1us = (pre_cnt == PRE_LAST);
  assign tick_1ms = tick_1us && (ms_cnt == MS_LAST);

  // Prescaler: count 0..NUM_1US_CLKS and wrap, strobing on the terminal count
  always_ff @(posedge clk or posedge arst) begin
    if (arst)          pre_cnt <= '0;
    else if (tick_1us) pre_cnt <= '0;
    else               pre_cnt <= pre_cnt + cnt_1us_t'(1);
  end

  // ms divider: count microsecond strobes 0..MS_DIV-1
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      ms_cnt <= '0;
    end else if (tick_1us) begin
      if (ms_cnt == MS_LAST) ms_cnt <= '0;
      else                   ms_cnt <= ms_cnt + MS_W'(1);
    end
  end

endmodule

// File: rtl/soc_timebase.sv
// SOC timebase: 1 us / 1 ms strobes, free-running us counter, and a periodic/one-shot timer with CSRs.
// Latency: bus_rdy and registered bus_rdat one cycle after bus_req; irq one cycle after the expiring tick.
// Backpressure: none; every request completes in one cycle and requests may issue back to back.
module soc_timebase #(
  parameter int NUM_1US_CLKS = soc_pkg::NUM_1US_CLKS,
  parameter int MS_DIV       = 1000
) (
  input  logic                clk,
  input  logic                arst,
  output logic                tick_1us,
  output logic                tick_1ms,
  output logic [31:0]         usec_cnt,
  output logic                irq,
  input  logic                bus_req,
  input  soc_pkg::soc_addr_t  bus_addr,
  input  soc_pkg::soc_we_t    bus_we,
  input  soc_pkg::soc_data_t  bus_wdat,
  output logic                bus_rdy,
  output soc_pkg::soc_data_t  bus_rdat
);
  import soc_pkg::*;

  tb_ctrl_t  ctrl_q, ctrl_d;
  soc_data_t load_q, load_d;
  soc_data_t count_q, count_d;
  logic      expired_q, expired_d;
  logic      fire, oneshot_clr;

  logic [2:0] sel;
  logic       wr_en, wr_ctrl, wr_load, w1c_status;
  soc_data_t  rd_mux;
  logic       unused_addr;

  soc_timebase_div #(
    .NUM_1US_CLKS (NUM_1US_CLKS),
    .MS_DIV       (MS_DIV)
  ) u_div (
    .clk      (clk),
    .arst     (arst),
    .tick_1us (tick_1us),
    .tick_1ms (tick_1ms)
  );

  // Only the word index inside the 8-register window is decoded
  assign sel         = bus_addr[4:2];
  assign unused_addr = ^{bus_addr[31:5], bus_addr[1:0]};

  // CTRL only has live bits in byte 0, so its byte-0 enable gates the whole write
  assign wr_en      = bus_req && (bus_we != '0);
  assign wr_ctrl    = wr_en && (sel == TB_CTRL) && bus_we[0];
  assign wr_load    = wr_en && (sel == TB_LOAD);
  assign w1c_status = wr_en && (sel == TB_STATUS) && bus_we[0] && bus_wdat[0];

  assign irq = expired_q;

  // Timer and CSR next state: hardware countdown first, then software writes layered on top
  always_comb begin
    ctrl_d      = ctrl_q;
    load_d      = load_q;
    count_d     = count_q;
    expired_d   = expired_q;
    fire        = 1'b0;
    oneshot_clr = 1'b0;

    // Count down only while enabled with a non-zero count; a zero count is a parked timer
    if (ctrl_q.en && tick_1us && (count_q != '0)) begin
      if (count_q == 32'd1) begin
        fire = 1'b1;
        if (ctrl_q.oneshot) begin
          count_d     = '0;
          ctrl_d.en   = 1'b0;
          oneshot_clr = 1'b1;
        end else begin
          count_d = load_q;
        end
      end else begin
        count_d = count_q - 32'd1;
      end
    end

    // A LOAD write always restarts the countdown, overriding a same-cycle decrement
    if (wr_load) begin
      load_d  = apply_byte_we(load_q, bus_wdat, bus_we);
      count_d = load_d;
    end

    // One-shot auto-clear of EN beats a software write; ONESHOT still takes the written value
    if (wr_ctrl) begin
      ctrl_d.oneshot = bus_wdat[1];
      if (!oneshot_clr) ctrl_d.en = bus_wdat[0];
      if (bus_wdat[0] && !ctrl_q.en) count_d = load_q;
    end

    // Expiry set wins over a same-cycle write-1-to-clear
    if (w1c_status) expired_d = 1'b0;
    if (fire)       expired_d = 1'b1;
  end

  // Read mux over current register state; unused addresses and bits read as zero
  always_comb begin
    rd_mux = '0;
    case (sel)
      TB_CTRL:   rd_mux = {30'd0, ctrl_q};
      TB_LOAD:   rd_mux = load_q;
      TB_COUNT:  rd_mux = count_q;
      TB_STATUS: rd_mux = {31'd0, expired_q};
      TB_USEC:   rd_mux = usec_cnt;
      default:   rd_mux = '0;
    endcase
  end

  // Timer and CSR state registers
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      ctrl_q    <= '0;
      load_q    <= '0;
      count_q   <= '0;
      expired_q <= 1'b0;
    end else begin
      ctrl_q    <= ctrl_d;
      load_q    <= load_d;
      count_q   <= count_d;
      expired_q <= expired_d;
    end
  end

  // Free-running microsecond counter, wraps silently
  always_ff @(posedge clk or posedge arst) begin
    if (arst)          usec_cnt <= '0;
    else if (tick_1us) usec_cnt <= usec_cnt + 32'd1;
  end

  // Single-cycle bus response; read data reflects state before any same-cycle write
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      bus_rdy  <= 1'b0;
      bus_rdat <= '0;
    end else begin
      bus_rdy  <= bus_req;
      bus_rdat <= bus_req ? rd_mux : '0;
    end
  end

endmodule

// File: tb/tb_soc_timebase.sv
// Self-checking bench for soc_timebase: vector table, directed corner sequences, random CSR traffic.
// Reference model tracks time as absolute microsecond ticks and the timer as an expiry deadline.
// Outputs are compared on the falling edge after every rising edge.
module tb_soc_timebase;
  import soc_pkg::*;

  localparam longint PER    = 80;
  localparam longint MS_PER = 80000;

  logic       clk = 1'b0;
  logic       arst = 1'b0;
  logic       tick_1us, tick_1ms, irq, bus_req, bus_rdy;
  logic [31:0] usec_cnt;
  soc_addr_t  bus_addr;
  soc_we_t    bus_we;
  soc_data_t  bus_wdat, bus_rdat;

  int errors = 0;
  int checks = 0;

  // Reference model state
  longint      edges = 0;
  logic        m_en, m_os, m_exp, m_run;
  logic [31:0] m_load, m_frozen;
  longint      m_deadline;

  // Observations
  longint first_tick = -1;
  longint ms_edge = -1;
  int     n_us = 0;
  int     n_ms = 0;

  typedef struct {
    logic [2:0]  addr;
    logic [3:0]  we;
    logic [31:0] wdat;
    logic [31:0] exp;
  } vec_t;

  soc_timebase dut (
    .clk      (clk),
    .arst     (arst),
    .tick_1us (tick_1us),
    .tick_1ms (tick_1ms),
    .usec_cnt (usec_cnt),
    .irq      (irq),
    .bus_req  (bus_req),
    .bus_addr (bus_addr),
    .bus_we   (bus_we),
    .bus_wdat (bus_wdat),
    .bus_rdy  (bus_rdy),
    .bus_rdat (bus_rdat)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edges);
      if (errors >= 100) begin
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
      end
    end
  endtask

  function automatic logic [31:0] model_count(longint t);
    return m_run ? 32'(m_deadline - t) : m_frozen;
  endfunction

  function automatic logic [31:0] model_read(logic [2:0] a, longint t);
    case (a)
      3'd0:    return {30'd0, m_os, m_en};
      3'd1:    return m_load;
      3'd2:    return model_count(t);
      3'd3:    return {31'd0, m_exp};
      3'd4:    return 32'(t);
      default: return 32'd0;
    endcase
  endfunction

  // Restart the countdown from value v at absolute tick t
  task automatic set_count(input logic [31:0] v, input longint t);
    if (m_en && v != 0) begin
      m_run = 1'b1;
      m_deadline = t + longint'(v);
    end else begin
      m_run = 1'b0;
      m_frozen = v;
    end
  endtask

  task automatic model_clear();
    edges = 0; m_en = 0; m_os = 0; m_exp = 0; m_run = 0;
    m_load = 0; m_frozen = 0; m_deadline = 0;
    first_tick = -1; ms_edge = -1; n_us = 0; n_ms = 0;
  endtask

  // One clock: apply the driven bus inputs to the model, then compare all outputs
  task automatic step();
    logic        rq, wr, tk, fire, os_fired;
    logic [2:0]  a;
    logic [31:0] rd_exp;
    longint      t_before, t_after;
    @(posedge clk);
    rq = bus_req;
    a  = bus_addr[4:2];
    wr = rq && (bus_we != 4'h0);
    edges++;
    t_before = (edges - 1) / PER;
    t_after  = edges / PER;
    tk       = (edges % PER == 0);
    rd_exp   = model_read(a, t_before);
    fire     = 1'b0;
    os_fired = 1'b0;
    if (m_run && tk && t_after == m_deadline) begin
      fire = 1'b1;
      if (m_os) begin
        os_fired = 1'b1;
        m_run = 0; m_frozen = 0; m_en = 0;
      end else begin
        m_deadline = t_after + longint'(m_load);
      end
    end
    if (wr && a == 3'd1) begin
      for (int b = 0; b < 4; b++) if (bus_we[b]) m_load[8*b +: 8] = bus_wdat[8*b +: 8];
      set_count(m_load, t_after);
    end
    if (wr && a == 3'd0 && bus_we[0]) begin
      if (!os_fired) begin
        if (bus_wdat[0] && !m_en) begin
          m_en = 1'b1;
          set_count(m_load, t_after);
        end else if (!bus_wdat[0] && m_en) begin
          m_frozen = model_count(t_after);
          m_run = 1'b0;
          m_en = 1'b0;
        end
      end
      m_os = bus_wdat[1];
    end
    if (wr && a == 3'd3 && bus_we[0] && bus_wdat[0]) m_exp = 1'b0;
    if (fire) m_exp = 1'b1;

    @(negedge clk);
    check("cycle_outputs", {tick_1us, tick_1ms, irq, bus_rdy, usec_cnt},
          {((edges + 1) % PER == 0), ((edges + 1) % MS_PER == 0), m_exp, rq, 32'(t_after)});
    if (rq) check("cycle_rdat", bus_rdat, rd_exp);
    if (tick_1us) begin
      n_us++;
      if (first_tick < 0) first_tick = edges + 1;
    end
    if (tick_1ms) begin
      n_ms++;
      ms_edge = edges + 1;
    end
  endtask

  task automatic bus(input logic [2:0] a, input logic [3:0] we, input logic [31:0] d, output logic [31:0] rd);
    bus_req  = 1'b1;
    bus_addr = ($urandom & 32'hFFFF_FFE3) | {27'd0, a, 2'b00};
    bus_we   = we;
    bus_wdat = d;
    step();
    rd = bus_rdat;
    bus_req = 1'b0;
    bus_we  = 4'h0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_tick_1us"}, tick_1us, 0);
    check({tag, "_tick_1ms"}, tick_1ms, 0);
    check({tag, "_usec_cnt"}, usec_cnt, 0);
    check({tag, "_irq"}, irq, 0);
    check({tag, "_bus_rdy"}, bus_rdy, 0);
    check({tag, "_bus_rdat"}, bus_rdat, 0);
  endtask

  task automatic wait_irq(input int budget, output longint at);
    at = -1;
    for (int i = 0; i < budget && at < 0; i++) begin
      step();
      if (irq) at = edges;
    end
    check("irq_timeout", (at >= 0), 1);
  endtask

  // Advance until the model count equals cnt and the next rising edge is a tick edge
  task automatic wait_phase(input logic [31:0] cnt, input int budget);
    bit ok;
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      if (m_run && model_count(edges / PER) == cnt && ((edges + 1) % PER == 0)) begin
        ok = 1;
        break;
      end
      step();
    end
    check("race_setup", ok, 1);
  endtask

  initial begin
    vec_t        vecs[21];
    logic [31:0] rd;
    longint      at0, at1, at2, at3;
    logic [2:0]  a;
    logic [3:0]  we;
    logic [31:0] d;
    int          r;

    vecs[0]  = '{3'd1, 4'hF, 32'h0000_0000, 32'h0};
    vecs[1]  = '{3'd1, 4'h0, 32'h0,         32'h0000_0000};
    vecs[2]  = '{3'd1, 4'h3, 32'hFFFF_1234, 32'h0};
    vecs[3]  = '{3'd1, 4'h0, 32'h0,         32'h0000_1234};
    vecs[4]  = '{3'd2, 4'h0, 32'h0,         32'h0000_1234};
    vecs[5]  = '{3'd1, 4'hC, 32'hABCD_0000, 32'h0};
    vecs[6]  = '{3'd1, 4'h0, 32'h0,         32'hABCD_1234};
    vecs[7]  = '{3'd0, 4'hF, 32'hFFFF_FFFE, 32'h0};
    vecs[8]  = '{3'd0, 4'h0, 32'h0,         32'h0000_0002};
    vecs[9]  = '{3'd0, 4'hE, 32'hFFFF_FFFF, 32'h0};
    vecs[10] = '{3'd0, 4'h0, 32'h0,         32'h0000_0002};
    vecs[11] = '{3'd3, 4'hF, 32'hFFFF_FFFF, 32'h0};
    vecs[12] = '{3'd3, 4'h0, 32'h0,         32'h0000_0000};
    vecs[13] = '{3'd6, 4'hF, 32'hDEAD_BEEF, 32'h0};
    vecs[14] = '{3'd6, 4'h0, 32'h0,         32'h0000_0000};
    vecs[15] = '{3'd5, 4'h0, 32'h0,         32'h0000_0000};
    vecs[16] = '{3'd7, 4'h0, 32'h0,         32'h0000_0000};
    vecs[17] = '{3'd0, 4'hF, 32'h0000_0000, 32'h0};
    vecs[18] = '{3'd0, 4'h0, 32'h0,         32'h0000_0000};
    vecs[19] = '{3'd1, 4'hF, 32'h0000_0000, 32'h0};
    vecs[20] = '{3'd2, 4'h0, 32'h0,         32'h0000_0000};

    bus_req = 0; bus_addr = 0; bus_we = 0; bus_wdat = 0;

    // Reset and release
    @(negedge clk);
    arst = 1'b1;
    #1;
    check_all_zero("reset");
    repeat (2) @(negedge clk);
    arst = 1'b0;
    model_clear();

    repeat (100) step();
    check("first_tick_edge", first_tick, 80);
    check("usec_after_first_tick", usec_cnt, 1);
    check("irq_idle", irq, 0);

    // Register map vectors (timer disabled)
    foreach (vecs[i]) begin
      bus(vecs[i].addr, vecs[i].we, vecs[i].wdat, rd);
      if (vecs[i].we == 4'h0) check($sformatf("vec%0d_rdat", i), rd, vecs[i].exp);
    end

    // 1 ms strobe
    while (edges < 80005) step();
    check("ms_tick_count", n_ms, 1);
    check("ms_tick_edge", ms_edge, 80000);
    check("us_tick_count", n_us, 1000);
    check("usec_at_1ms", usec_cnt, 1000);

    // Periodic timer
    bus(3'd1, 4'hF, 32'd5, rd);
    bus(3'd0, 4'hF, 32'h1, rd);
    wait_irq(500, at1);
    bus(3'd3, 4'hF, 32'h1, rd);
    check("periodic_irq_cleared", irq, 0);
    wait_irq(500, at2);
    check("periodic_interval_1", at2 - at1, 400);
    bus(3'd3, 4'hF, 32'h1, rd);
    check("periodic_irq_cleared_2", irq, 0);
    wait_irq(500, at3);
    check("periodic_interval_2", at3 - at2, 400);

    // One-shot timer
    bus(3'd0, 4'hF, 32'h0, rd);
    bus(3'd3, 4'hF, 32'h1, rd);
    bus(3'd1, 4'hF, 32'd3, rd);
    bus(3'd0, 4'hF, 32'h3, rd);
    at0 = edges;
    wait_irq(300, at1);
    check("oneshot_delay_window", (at1 - at0 > 160) && (at1 - at0 <= 240), 1);
    bus(3'd0, 4'h0, 32'h0, rd);
    check("oneshot_ctrl", rd, 32'h2);
    bus(3'd2, 4'h0, 32'h0, rd);
    check("oneshot_count", rd, 32'h0);
    bus(3'd3, 4'hF, 32'h1, rd);
    repeat (400) step();
    check("oneshot_no_refire", irq, 0);

    // W1C on the expiry edge: set wins
    bus(3'd1, 4'hF, 32'd2, rd);
    bus(3'd0, 4'hF, 32'h1, rd);
    wait_phase(32'd1, 400);
    bus(3'd3, 4'hF, 32'h1, rd);
    bus(3'd3, 4'h0, 32'h0, rd);
    check("w1c_race_status", rd, 32'h1);

    // LOAD write on a decrement edge: write wins
    wait_phase(32'd2, 400);
    bus(3'd1, 4'hF, 32'd7, rd);
    bus(3'd2, 4'h0, 32'h0, rd);
    check("load_race_count", rd, 32'd7);

    // CTRL write on one-shot expiry: EN cleared, ONESHOT takes written value
    bus(3'd0, 4'hF, 32'h3, rd);
    wait_phase(32'd1, 800);
    bus(3'd0, 4'hF, 32'h1, rd);
    bus(3'd0, 4'h0, 32'h0, rd);
    check("ctrl_race_ctrl", rd, 32'h0);
    bus(3'd3, 4'h0, 32'h0, rd);
    check("ctrl_race_status", rd, 32'h1);

    // Random CSR traffic against the model
    bus(3'd0, 4'hF, 32'h0, rd);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) != 0) begin
        step();
      end else begin
        a = 3'($urandom_range(0, 7));
        if ($urandom_range(0, 1) == 1) a = 3'($urandom_range(0, 3));
        r  = $urandom_range(0, 3);
        we = (r == 0) ? 4'h0 : (r == 1) ? 4'($urandom) : 4'hF;
        d  = (a == 3'd1) ? 32'($urandom_range(0, 3)) : $urandom;
        bus(a, we, d, rd);
      end
    end

    // Async reset during an in-flight read
    @(negedge clk);
    bus_req = 1'b1; bus_addr = {27'd0, 3'd4, 2'b00}; bus_we = 4'h0;
    #2;
    arst = 1'b1;
    #1;
    check_all_zero("midreset");
    @(posedge clk);
    @(negedge clk);
    check("midreset_no_rdy", bus_rdy, 0);
    bus_req = 1'b0;
    @(negedge clk);
    arst = 1'b0;
    model_clear();
    repeat (100) step();
    check("restart_first_tick_edge", first_tick, 80);
    check("restart_usec", usec_cnt, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/soc_timebase.md
# soc_timebase

Free-running SOC timebase and programmable microsecond timer. Divides the system clock into a 1 µs strobe using the shared timebase constants. Derives a 1 ms strobe and a 32-bit microsecond counter. Exposes a periodic/one-shot timer with interrupt through a simple single-cycle CSR port on the SOC bus.

## Interface
- `NUM_1US_CLKS`, default `soc_pkg::NUM_1US_CLKS` (79 at 80 MHz): prescaler terminal count.
- `MS_DIV`, default 1000: number of 1 µs ticks per 1 ms tick.
- `clk`  in  1: system clock.
- `arst`  in  1: reset, asynchronous, active-high.
- `tick_1us`  out  1: one-clock strobe every `NUM_1US_CLKS+1` clocks.
- `tick_1ms`  out  1: one-clock strobe, coincident with every `MS_DIV`-th `tick_1us`.
- `usec_cnt`  out  32: free-running µs counter.
- `irq`  out  1: equals `STATUS.EXPIRED`.
- `bus_req`  in  1: CSR access request.
- `bus_addr`  in  `soc_addr_t`: word address; only `[4:2]` decoded.
- `bus_we`  in  `soc_we_t`: byte write enables; all-zero means read.
- `bus_wdat`  in  `soc_data_t`: write data.
- `bus_rdy`  out  1: access complete.
- `bus_rdat`  out  `soc_data_t`: read data, valid while `bus_rdy` is high.

## Operation
- **Prescaler:** `cnt_1us_t` counter runs 0..`NUM_1US_CLKS`, then wraps to 0. `tick_1us` is high exactly in the cycle where the count equals `NUM_1US_CLKS`.
- **ms divider:** counts `tick_1us` from 0..`MS_DIV-1`. `tick_1ms` is `tick_1us` AND (count == `MS_DIV-1`).
- **`usec_cnt`:** increments on `tick_1us`. Wraps from 0xFFFF_FFFF to 0 with no flag.
- **Register map** (`bus_addr[4:2]`):
  - 0 CTRL: bit0 EN, bit1 ONESHOT.
  - 1 LOAD: period in µs.
  - 2 COUNT: read-only.
  - 3 STATUS: bit0 EXPIRED, write-1-to-clear.
  - 4 USEC: read-only, mirrors `usec_cnt`.
  - 5..7 read 0, writes ignored. Unused register bits read 0.
- **Writes:** byte enables are honoured per byte on CTRL and LOAD.
- **COUNT reload:** COUNT ← LOAD on any LOAD write, and on a CTRL write that takes EN from 0 to 1. A CTRL write with EN already set does not reload.
- **Timer:** counts only while EN=1, on `tick_1us`, with COUNT ≠ 0.
  - COUNT > 1: decrement.
  - COUNT == 1: set EXPIRED.
    - Periodic (ONESHOT=0): COUNT ← LOAD.
    - One-shot (ONESHOT=1): COUNT ← 0 and EN ← 0.
- **LOAD = 0:** COUNT stays 0 and the timer never expires.
- **Simultaneous events:**
  - Expiry and W1C of EXPIRED in the same cycle: set wins, EXPIRED stays 1.
  - Software LOAD write and tick decrement in the same cycle: the write wins.
  - Software CTRL write and one-shot auto-clear in the same cycle: the auto-clear of EN wins, but ONESHOT takes the written value.

## Timing
- **Reset:** all outputs and registers go to 0 asynchronously on `arst`. This covers `tick_*`, `usec_cnt`, `irq`, `bus_rdy`, `bus_rdat`, CTRL, LOAD, COUNT, STATUS and both dividers.
- **First tick:** the first `tick_1us` occurs on the 80th rising edge after `arst` deasserts (`NUM_1US_CLKS`=79). The period is exactly 80 clocks thereafter.
- **Register update:** `usec_cnt`, COUNT and EXPIRED update on the edge ending the `tick_1us` cycle. `irq` rises in the following cycle.
- **Bus handshake:**
  - `bus_rdy` is high one cycle after `bus_req` and lasts one clock.
  - Writes take effect on the `bus_req` edge.
  - `bus_rdat` is registered and shows register state sampled at the `bus_req` edge.
  - Back-to-back requests are allowed every cycle.
  - `bus_req` is ignored while `arst` is active.
- **Reset mid-operation:** an in-flight access is dropped; no `bus_rdy` is issued.

## Structure
- **`soc_pkg` additions:**
  - Existing: `cnt_1us_t`, `NUM_1US_CLKS`, `soc_addr_t`, `soc_we_t`, `soc_data_t`.
  - New: register offset constants `TB_CTRL`, `TB_LOAD`, `TB_COUNT`, `TB_STATUS`, `TB_USEC`.
  - New: packed struct `tb_ctrl_t` {oneshot, en}.
- **Sub-module:** one, `soc_timebase_div`, which holds the prescaler plus ms divider and produces `tick_1us`/`tick_1ms`. The CSR and timer logic stay in the top.

## Test plan
- **Reset release:** release `arst`, count clocks → `tick_1us` at edge 80, then every 80 clocks. Check `usec_cnt`=1 after the first tick and no `irq`.
- **1 ms tick:** run 80 000 clocks → exactly one `tick_1ms`, coincident with the 1000th `tick_1us`. `usec_cnt`=1000.
- **Periodic timer:** LOAD=5, CTRL=0x1 → `irq` every 5 µs (400 clocks). Clearing STATUS with 0x1 between expiries drops `irq`; each next expiry re-asserts it.
- **One-shot timer:** LOAD=3, CTRL=0x3 → single expiry after 3 µs. CTRL reads 0x2, COUNT reads 0, no further expiry.
- **Byte-enable write and W1C race:**
  - LOAD=0 then write 0xFFFF_1234 with `bus_we`=4'b0011 → LOAD reads 0x0000_1234.
  - W1C STATUS on the expiry cycle → EXPIRED reads 1.
- **Async reset mid-count:** assert `arst` mid-count during an active read → all outputs 0 immediately, no `bus_rdy`. After release, the prescaler restarts so the first tick is again at edge 80.
